// File: rtl/pio_arbiter.sv
// pio_arbiter: round-robin arbiter sharing one PIO command bus between up to
// four requesters. One transaction is in flight at a time. The arbiter issues
// the command, waits for a read response, and returns the data to the
// requester that owns the read.
// Optional feature macro: PIO_ARB_TIMEOUT_EN. When it is defined, a read that
// gets no response within TIMEOUT cycles completes with 32'hDEAD_BEEF and
// req_rd_err=1.
module pio_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_cmd_vld,
  input  logic [NUM_REQ-1:0]      req_rw,
  input  logic [16*NUM_REQ-1:0]   req_addr,
  input  logic [32*NUM_REQ-1:0]   req_data_w,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [NUM_REQ-1:0]      req_rd_vld,
  output logic [31:0]             req_data_r,
  output logic                    req_rd_err,
  output logic                    pio_cmd_vld,
  output logic [15:0]             pio_addr,
  output logic [31:0]             pio_data_w,
  output logic                    pio_rw,
  input  logic                    pio_rd_vld,
  input  logic [31:0]             pio_data_r,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t             state;
  logic [1:0]         ptr;
  logic [NUM_REQ-1:0] owner;

  // Per-requester fields unpacked into four slots; slots beyond NUM_REQ read as 0
  logic        vld_a  [4];
  logic        rw_a   [4];
  logic [15:0] addr_a [4];
  logic [31:0] data_a [4];

  for (genvar i = 0; i < 4; i++) begin : g_slot
    if (i < NUM_REQ) begin : g_used
      assign vld_a[i]  = req_cmd_vld[i];
      assign rw_a[i]   = req_rw[i];
      assign addr_a[i] = req_addr[16*i +: 16];
      assign data_a[i] = req_data_w[32*i +: 32];
    end else begin : g_empty
      assign vld_a[i]  = 1'b0;
      assign rw_a[i]   = 1'b0;
      assign addr_a[i] = '0;
      assign data_a[i] = '0;
    end
  end

  logic               found;
  logic [1:0]         pick;
  logic [NUM_REQ-1:0] pick_oh;
  logic [1:0]         ptr_nxt;
  logic [2:0]         sum;
  logic [2:0]         inc;

  // Round-robin search: first active requester at or above ptr, wrapping at NUM_REQ
  always_comb begin
    found   = 1'b0;
    pick    = 2'd0;
    sum     = 3'd0;
    pick_oh = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + 3'(k);
      if (sum >= 3'(NUM_REQ)) sum = sum - 3'(NUM_REQ);
      if (!found && vld_a[sum[1:0]]) begin
        found = 1'b1;
        pick  = sum[1:0];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_oh[i] = (32'(pick) == i);
    end
    inc = {1'b0, pick} + 3'd1;
    if (inc >= 3'(NUM_REQ)) inc = 3'd0;
    ptr_nxt = inc[1:0];
  end

`ifdef PIO_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt;
`else
  assign req_rd_err = 1'b0;
`endif

  // Control FSM with registered command, handshake and response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      owner       <= '0;
      req_ack     <= '0;
      req_rd_vld  <= '0;
      req_data_r  <= '0;
      pio_cmd_vld <= 1'b0;
      pio_addr    <= '0;
      pio_data_w  <= '0;
      pio_rw      <= 1'b0;
      busy        <= 1'b0;
`ifdef PIO_ARB_TIMEOUT_EN
      cnt         <= '0;
      req_rd_err  <= 1'b0;
`endif
    end else begin
      req_ack     <= '0;
      req_rd_vld  <= '0;
      pio_cmd_vld <= 1'b0;
`ifdef PIO_ARB_TIMEOUT_EN
      req_rd_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            owner       <= pick_oh;
            pio_addr    <= addr_a[pick];
            pio_data_w  <= data_a[pick];
            pio_rw      <= rw_a[pick];
            pio_cmd_vld <= 1'b1;
            req_ack     <= pick_oh;
            ptr         <= ptr_nxt;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (pio_rw) begin
`ifdef PIO_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
            state <= WAIT_RD;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        WAIT_RD: begin
          if (pio_rd_vld) begin
            req_data_r <= pio_data_r;
            req_rd_vld <= owner;
            state      <= RESP;
          end
`ifdef PIO_ARB_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            req_data_r <= 32'hDEAD_BEEF;
            req_rd_vld <= owner;
            req_rd_err <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
`endif
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pio_arbiter.sv
// Directed testbench for pio_arbiter with NUM_REQ=2 and TIMEOUT=8.
// The timeout scenario is exercised only when PIO_ARB_TIMEOUT_EN is defined.
module tb_pio_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_cmd_vld;
  logic [1:0]  req_rw;
  logic [31:0] req_addr;
  logic [63:0] req_data_w;
  logic [1:0]  req_ack;
  logic [1:0]  req_rd_vld;
  logic [31:0] req_data_r;
  logic        req_rd_err;
  logic        pio_cmd_vld;
  logic [15:0] pio_addr;
  logic [31:0] pio_data_w;
  logic        pio_rw;
  logic        pio_rd_vld;
  logic [31:0] pio_data_r;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  pio_arbiter #(.NUM_REQ(2), .TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_cmd_vld (req_cmd_vld),
    .req_rw      (req_rw),
    .req_addr    (req_addr),
    .req_data_w  (req_data_w),
    .req_ack     (req_ack),
    .req_rd_vld  (req_rd_vld),
    .req_data_r  (req_data_r),
    .req_rd_err  (req_rd_err),
    .pio_cmd_vld (pio_cmd_vld),
    .pio_addr    (pio_addr),
    .pio_data_w  (pio_data_w),
    .pio_rw      (pio_rw),
    .pio_rd_vld  (pio_rd_vld),
    .pio_data_r  (pio_data_r),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b0;
    req_cmd_vld = '0;
    req_rw      = '0;
    req_addr    = '0;
    req_data_w  = '0;
    pio_rd_vld  = 1'b0;
    pio_data_r  = '0;

    // Reset state
    tick();
    tick();
    chk("rst_cmd_vld", 32'(pio_cmd_vld), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_rd_vld", 32'(req_rd_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(pio_addr), 32'd0);
    chk("rst_data_r", req_data_r, 32'd0);
    reset = 1'b1;
    tick();

    // Single write from requester 0
    req_cmd_vld      = 2'b01;
    req_rw           = 2'b00;
    req_addr[15:0]   = 16'h0010;
    req_data_w[31:0] = 32'h1234_5678;
    tick();
    chk("wr_cmd_vld", 32'(pio_cmd_vld), 32'd1);
    chk("wr_rw", 32'(pio_rw), 32'd0);
    chk("wr_addr", 32'(pio_addr), 32'h0010);
    chk("wr_data", pio_data_w, 32'h1234_5678);
    chk("wr_ack", 32'(req_ack), 32'b01);
    chk("wr_busy", 32'(busy), 32'd1);
    req_cmd_vld = 2'b00;
    tick();
    chk("wr_busy_drop", 32'(busy), 32'd0);
    chk("wr_ack_pulse", 32'(req_ack), 32'd0);
    chk("wr_cmd_pulse", 32'(pio_cmd_vld), 32'd0);

    // Read from requester 1, response three cycles after issue
    req_cmd_vld       = 2'b10;
    req_rw            = 2'b10;
    req_addr[31:16]   = 16'h0020;
    tick();
    chk("rd_ack", 32'(req_ack), 32'b10);
    chk("rd_rw", 32'(pio_rw), 32'd1);
    chk("rd_addr", 32'(pio_addr), 32'h0020);
    req_cmd_vld = 2'b00;
    tick();
    tick();
    chk("rd_wait_vld", 32'(req_rd_vld), 32'd0);
    chk("rd_wait_busy", 32'(busy), 32'd1);
    tick();
    pio_rd_vld = 1'b1;
    pio_data_r = 32'hCAFE_0001;
    tick();
    pio_rd_vld = 1'b0;
    pio_data_r = 32'h0;
    chk("rd_vld", 32'(req_rd_vld), 32'b10);
    chk("rd_data", req_data_r, 32'hCAFE_0001);
    chk("rd_err", 32'(req_rd_err), 32'd0);
    tick();
    chk("rd_vld_pulse", 32'(req_rd_vld), 32'd0);
    chk("rd_idle_busy", 32'(busy), 32'd0);

    // Contention: both requesters hold writes; grants alternate 0,1,0,1
    req_cmd_vld      = 2'b11;
    req_rw           = 2'b00;
    req_addr         = {16'h00B1, 16'h00A0};
    req_data_w       = {32'h1111_1111, 32'h0000_0000};
    tick();
    chk("ct_ack0", 32'(req_ack), 32'b01);
    chk("ct_addr0", 32'(pio_addr), 32'h00A0);
    tick();
    chk("ct_gap0", 32'(req_ack), 32'b00);
    tick();
    chk("ct_ack1", 32'(req_ack), 32'b10);
    chk("ct_addr1", 32'(pio_addr), 32'h00B1);
    chk("ct_data1", pio_data_w, 32'h1111_1111);
    tick();
    chk("ct_gap1", 32'(req_ack), 32'b00);
    tick();
    chk("ct_ack2", 32'(req_ack), 32'b01);
    tick();
    chk("ct_gap2", 32'(req_ack), 32'b00);
    tick();
    chk("ct_ack3", 32'(req_ack), 32'b10);
    req_cmd_vld = 2'b00;
    tick();
    chk("ct_idle", 32'(busy), 32'd0);

    // Stray response while idle
    pio_rd_vld = 1'b1;
    pio_data_r = 32'h5555_AAAA;
    tick();
    chk("stray_rd_vld", 32'(req_rd_vld), 32'd0);
    chk("stray_busy", 32'(busy), 32'd0);
    tick();
    chk("stray_rd_vld2", 32'(req_rd_vld), 32'd0);
    pio_rd_vld = 1'b0;

`ifdef PIO_ARB_TIMEOUT_EN
    // Timeout: read with no response completes TIMEOUT+1 cycles after issue
    req_cmd_vld    = 2'b01;
    req_rw         = 2'b01;
    req_addr[15:0] = 16'h0030;
    tick();
    chk("to_ack", 32'(req_ack), 32'b01);
    req_cmd_vld = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("to_wait", 32'(req_rd_vld), 32'd0);
    end
    tick();
    chk("to_rd_vld", 32'(req_rd_vld), 32'b01);
    chk("to_data", req_data_r, 32'hDEAD_BEEF);
    chk("to_err", 32'(req_rd_err), 32'd1);
    pio_rd_vld = 1'b1;
    pio_data_r = 32'h0BAD_0BAD;
    tick();
    chk("to_late_vld", 32'(req_rd_vld), 32'd0);
    chk("to_late_err", 32'(req_rd_err), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
    tick();
    chk("to_late_vld2", 32'(req_rd_vld), 32'd0);
    chk("to_late_busy", 32'(busy), 32'd0);
    pio_rd_vld = 1'b0;
    pio_data_r = 32'h0;
`endif

    // Reset during WAIT_RD aborts the read
    req_cmd_vld    = 2'b01;
    req_rw         = 2'b01;
    req_addr[15:0] = 16'h0040;
    tick();
    chk("mr_ack", 32'(req_ack), 32'b01);
    req_cmd_vld = 2'b00;
    tick();
    tick();
    chk("mr_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_addr", 32'(pio_addr), 32'd0);
    chk("mr_rw", 32'(pio_rw), 32'd0);
    chk("mr_rd_vld", 32'(req_rd_vld), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("mr_no_stale", 32'(req_rd_vld), 32'd0);
    req_cmd_vld    = 2'b01;
    req_addr[15:0] = 16'h0050;
    tick();
    chk("mr2_ack", 32'(req_ack), 32'b01);
    chk("mr2_addr", 32'(pio_addr), 32'h0050);
    req_cmd_vld = 2'b00;
    tick();
    chk("mr2_wait", 32'(req_rd_vld), 32'd0);
    pio_rd_vld = 1'b1;
    pio_data_r = 32'h0000_0055;
    tick();
    pio_rd_vld = 1'b0;
    chk("mr2_rd_vld", 32'(req_rd_vld), 32'b01);
    chk("mr2_data", req_data_r, 32'h0000_0055);
    chk("mr2_err", 32'(req_rd_err), 32'd0);
    tick();
    chk("mr2_idle", 32'(busy), 32'd0);
    chk("mr2_vld_pulse", 32'(req_rd_vld), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pio_arbiter.md
# pio_arbiter

Round-robin arbiter that shares the single PIO command bus between up to four requesters (host decoder, debug port, DMA, boot loader). It accepts one command per requester at a time, drives one PIO command, tracks the outstanding read, and routes the read response to the requester that issued it. It sits between the host-side decoders and the PIO register block, and holds at most one transaction in flight.

## Interface
- NUM_REQ, default 2: number of requesters, legal range 1–4.
- TIMEOUT, default 256: read-wait limit in cycles, legal range 1–65535. Used only with PIO_ARB_TIMEOUT_EN.
- clk, in, 1: single clock; all logic on its rising edge.
- reset, in, 1: asynchronous, active-low reset.
- req_cmd_vld, in, NUM_REQ: per-requester command request. Held high until req_ack.
- req_rw, in, NUM_REQ: 1 = read, 0 = write.
- req_addr, in, 16*NUM_REQ: requester i uses bits [16i+15:16i].
- req_data_w, in, 32*NUM_REQ: requester i uses bits [32i+31:32i].
- req_ack, out, NUM_REQ: one-cycle pulse; the command has been issued on PIO.
- req_rd_vld, out, NUM_REQ: one-cycle pulse to the read owner; data is valid.
- req_data_r, out, 32: read data, shared by all requesters and qualified by req_rd_vld.
- req_rd_err, out, 1: high together with req_rd_vld when the read timed out.
- pio_cmd_vld, out, 1: one-cycle command strobe.
- pio_addr, out, 16: command address.
- pio_data_w, out, 32: command write data.
- pio_rw, out, 1: 1 = read, 0 = write.
- pio_rd_vld, in, 1: read response strobe.
- pio_data_r, in, 32: read response data.
- busy, out, 1: high when the state is not IDLE.

## Operation
- **States.**
  - IDLE: arbitrate.
  - ISSUE: drive the PIO command.
  - WAIT_RD: wait for the read response.
  - RESP: return data to the owner.
- **IDLE.**
  - If any req_cmd_vld is high, choose a winner g by round-robin.
  - Search starts at pointer ptr and wraps through NUM_REQ−1 back to 0.
  - Latch g and its rw/addr/data_w, then go to ISSUE.
  - Set ptr to (g+1) mod NUM_REQ.
- **ISSUE.**
  - Drive pio_cmd_vld=1 with the latched fields and pulse req_ack[g].
  - Write: go to IDLE. Read: clear the wait counter and go to WAIT_RD.
- **WAIT_RD.**
  - On pio_rd_vld: capture pio_data_r and go to RESP.
  - Otherwise, with the macro enabled, the counter increments each cycle. When it reaches TIMEOUT−1 without a response, capture 32'hDEAD_BEEF, set the error flag and go to RESP.
- **RESP.** Pulse req_rd_vld[g], drive req_data_r and drive req_rd_err = error flag, then go to IDLE.
- **Responses outside WAIT_RD.** pio_rd_vld in IDLE, ISSUE or RESP (a stray or late response) is ignored and changes no state.
- **Request changes.** Requesters must not change their fields while req_cmd_vld is high and unacknowledged. Deasserting req_cmd_vld before ack withdraws the request with no effect.
- **Reset values.**
  - state = IDLE, ptr = 0, counter = 0, error flag = 0.
  - All outputs are 0: pio_cmd_vld, pio_addr, pio_data_w, pio_rw, req_ack, req_rd_vld, req_data_r, req_rd_err, busy.
- **Reset mid-operation.** Asserting reset aborts any transaction immediately. No response is delivered afterwards.

## Timing
- Request sampled high in IDLE at cycle N: pio_cmd_vld and req_ack[g] both high at N+1.
- Write: back to IDLE at N+2. The next grant can be issued at N+3, so the sustained write rate is one command per 2 cycles.
- Read with pio_rd_vld at cycle M (M ≥ N+2): req_rd_vld[g] high at M+1 and IDLE at M+2.
- Read timeout: req_rd_vld with req_rd_err=1 exactly TIMEOUT+1 cycles after the ISSUE cycle.
- Simultaneous requests: the requester nearest ptr (upwards, wrapping) wins. The others keep waiting, and each is served within NUM_REQ grants.
- req_ack and req_rd_vld are never high for more than one cycle, and are each one-hot or zero.

## Configuration
- Macro: PIO_ARB_TIMEOUT_EN.
- **Defined:** the wait counter and TIMEOUT are active. A timed-out read returns 32'hDEAD_BEEF with req_rd_err=1.
- **Undefined:**
  - The counter is not built.
  - WAIT_RD waits indefinitely for pio_rd_vld.
  - req_rd_err is tied to 0.

## Test plan
- Reset then single write: req0 writes addr 16'h0010, data 32'h1234_5678 → pio_cmd_vld=1 with pio_rw=0 one cycle after the request; req_ack[0] in the same cycle; busy drops the following cycle.
- Read: req1 reads addr 16'h0020, PIO returns 32'hCAFE_0001 three cycles after issue → req_rd_vld[1]=1 with data 32'hCAFE_0001 and req_rd_err=0 one cycle later; req_rd_vld[0] stays 0.
- Contention: req0 and req1 both hold write requests continuously after reset → grants alternate 0,1,0,1, with an ack every 2 cycles.
- Timeout (macro on, TIMEOUT=8): read issued and no pio_rd_vld → req_rd_vld with 32'hDEAD_BEEF and req_rd_err=1, 9 cycles after the issue cycle. A late pio_rd_vld afterwards is ignored.
- Stray response: pio_rd_vld pulsed while IDLE → no req_rd_vld and busy stays 0.
- Reset mid-read: reset asserted during WAIT_RD → all outputs 0 immediately. After release, a new req0 read completes normally with no stale response.
